ad_wb_arbiter: RTL and testbench

Writeback stage directly upstream of the register file. It merges two result sources into the regfile's single write port:
- single-cycle EX results, buffered in a small skid FIFO;
- variable-latency load responses, returned in issue order.

It also keeps a scoreboard of pending destination registers and raises a hazard flag so ID can stall on RAW/WAW conflicts the regfile's same-cycle write-through cannot cover.

---
 rtl/ad_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ad_wb_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_wb_arbiter.sv
// Writeback arbiter: merges EX results and in-order load responses onto the
// single regfile write port, and flags ID hazards on pending destinations.
module ad_wb_arbiter #(
  parameter int unsigned REG_DATA_WIDTH     = 32,
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned EX_FIFO_DEPTH      = 2,
  parameter int unsigned LD_PEND_DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          ex_valid_i,
  output logic                          ex_ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     ex_data_i,
  input  logic                          ld_issue_valid_i,
  output logic                          ld_issue_ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ld_issue_rd_i,
  input  logic                          ld_rsp_valid_i,
  input  logic [REG_DATA_WIDTH-1:0]     ld_rsp_data_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rd_addr_i,
  output logic                          hazard_o,
  output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
  output logic                          rd_wr_en_o,
  output logic                          ld_err_o
);

  localparam int unsigned EX_AW = $clog2(EX_FIFO_DEPTH);
  localparam int unsigned LD_AW = $clog2(LD_PEND_DEPTH);

  // EX skid FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [REGFILE_ADDR_WIDTH-1:0] ex_rd_mem   [EX_FIFO_DEPTH];
  logic [REG_DATA_WIDTH-1:0]     ex_data_mem [EX_FIFO_DEPTH];
  logic [EX_AW:0]                ex_wr_ptr;
  logic [EX_AW:0]                ex_rd_ptr;
  logic [EX_AW:0]                ex_count;
  logic                          ex_empty;
  logic                          ex_full;
  logic [EX_FIFO_DEPTH-1:0]      ex_entry_vld;

  // Pending-load table storage and pointers
  logic [REGFILE_ADDR_WIDTH-1:0] ld_rd_mem [LD_PEND_DEPTH];
  logic [LD_AW:0]                ld_wr_ptr;
  logic [LD_AW:0]                ld_rd_ptr;
  logic [LD_AW:0]                ld_count;
  logic                          ld_empty;
  logic                          ld_full;
  logic [LD_PEND_DEPTH-1:0]      ld_entry_vld;

  // Handshake and arbitration decisions
  logic ex_fire;
  logic ex_bypass;
  logic ex_push;
  logic ex_pop;
  logic ld_pop;
  logic ld_push;

  logic                          sel_valid;
  logic [REGFILE_ADDR_WIDTH-1:0] sel_rd;
  logic [REG_DATA_WIDTH-1:0]     sel_data;

  assign ex_count = ex_wr_ptr - ex_rd_ptr;
  assign ex_empty = (ex_count == '0);
  assign ex_full  = (ex_count == (EX_AW+1)'(EX_FIFO_DEPTH));

  assign ld_count = ld_wr_ptr - ld_rd_ptr;
  assign ld_empty = (ld_count == '0);
  assign ld_full  = (ld_count == (LD_AW+1)'(LD_PEND_DEPTH));

  assign ex_ready_o       = !ex_full;
  assign ld_issue_ready_o = !ld_full;

  // Load responses win; EX bypasses only when nothing older is waiting.
  assign ld_pop    = ld_rsp_valid_i && !ld_empty;
  assign ex_fire   = ex_valid_i && !ex_full;
  assign ex_pop    = !ld_pop && !ex_empty;
  assign ex_bypass = !ld_pop && ex_empty && ex_fire;
  assign ex_push   = ex_fire && !ex_bypass;
  // A full table still accepts an issue when the head retires this cycle.
  assign ld_push   = ld_issue_valid_i && (!ld_full || ld_pop);

  // Occupancy mask: entry i is live when its distance from the read pointer is below the count
  always_comb begin
    ex_entry_vld = '0;
    for (int i = 0; i < EX_FIFO_DEPTH; i++) begin
      ex_entry_vld[i] = ({1'b0, EX_AW'(i) - ex_rd_ptr[EX_AW-1:0]} < ex_count);
    end
    ld_entry_vld = '0;
    for (int i = 0; i < LD_PEND_DEPTH; i++) begin
      ld_entry_vld[i] = ({1'b0, LD_AW'(i) - ld_rd_ptr[LD_AW-1:0]} < ld_count);
    end
  end

  // Hazard: sources vs. all buffered destinations, ID rd vs. pending loads only
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < LD_PEND_DEPTH; i++) begin
      if (ld_entry_vld[i] && (ld_rd_mem[i] != '0) &&
          ((ld_rd_mem[i] == id_rs1_addr_i) || (ld_rd_mem[i] == id_rs2_addr_i) ||
           (ld_rd_mem[i] == id_rd_addr_i))) begin
        hazard_o = 1'b1;
      end
    end
    for (int i = 0; i < EX_FIFO_DEPTH; i++) begin
      if (ex_entry_vld[i] && (ex_rd_mem[i] != '0) &&
          ((ex_rd_mem[i] == id_rs1_addr_i) || (ex_rd_mem[i] == id_rs2_addr_i))) begin
        hazard_o = 1'b1;
      end
    end
  end

  // Write-port winner for this cycle
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (ld_pop) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rd_mem[ld_rd_ptr[LD_AW-1:0]];
      sel_data  = ld_rsp_data_i;
    end else if (ex_pop) begin
      sel_valid = 1'b1;
      sel_rd    = ex_rd_mem[ex_rd_ptr[EX_AW-1:0]];
      sel_data  = ex_data_mem[ex_rd_ptr[EX_AW-1:0]];
    end else if (ex_bypass) begin
      sel_valid = 1'b1;
      sel_rd    = ex_rd_addr_i;
      sel_data  = ex_data_i;
    end
  end

  // Queue payload storage; validity lives in the pointers so no reset needed
  always_ff @(posedge clk_i) begin
    if (ex_push) begin
      ex_rd_mem[ex_wr_ptr[EX_AW-1:0]]   <= ex_rd_addr_i;
      ex_data_mem[ex_wr_ptr[EX_AW-1:0]] <= ex_data_i;
    end
    if (ld_push) begin
      ld_rd_mem[ld_wr_ptr[LD_AW-1:0]] <= ld_issue_rd_i;
    end
  end

  // Pointers, registered write port and sticky error flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_wr_ptr    <= '0;
      ex_rd_ptr    <= '0;
      ld_wr_ptr    <= '0;
      ld_rd_ptr    <= '0;
      rd_addr_o    <= '0;
      rd_wr_data_o <= '0;
      rd_wr_en_o   <= 1'b0;
      ld_err_o     <= 1'b0;
    end else begin
      if (ex_push) ex_wr_ptr <= ex_wr_ptr + (EX_AW+1)'(1);
      if (ex_pop)  ex_rd_ptr <= ex_rd_ptr + (EX_AW+1)'(1);
      if (ld_push) ld_wr_ptr <= ld_wr_ptr + (LD_AW+1)'(1);
      if (ld_pop)  ld_rd_ptr <= ld_rd_ptr + (LD_AW+1)'(1);
      // x0 writes are suppressed; the regfile hardwires x0 anyway
      rd_wr_en_o <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        rd_addr_o    <= sel_rd;
        rd_wr_data_o <= sel_data;
      end
      if (ld_rsp_valid_i && ld_empty) ld_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ad_wb_arbiter.sv
// Self-checking bench for ad_wb_arbiter: directed scenarios then random traffic,
// compared against a queue-based reference of the writeback rules.
module tb_ad_wb_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int EXD = 2;
  localparam int LDD = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          ex_valid_i;
  logic          ex_ready_o;
  logic [AW-1:0] ex_rd_addr_i;
  logic [DW-1:0] ex_data_i;
  logic          ld_issue_valid_i;
  logic          ld_issue_ready_o;
  logic [AW-1:0] ld_issue_rd_i;
  logic          ld_rsp_valid_i;
  logic [DW-1:0] ld_rsp_data_i;
  logic [AW-1:0] id_rs1_addr_i;
  logic [AW-1:0] id_rs2_addr_i;
  logic [AW-1:0] id_rd_addr_i;
  logic          hazard_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_wr_data_o;
  logic          rd_wr_en_o;
  logic          ld_err_o;

  ad_wb_arbiter #(
    .REG_DATA_WIDTH    (DW),
    .REGFILE_ADDR_WIDTH(AW),
    .EX_FIFO_DEPTH     (EXD),
    .LD_PEND_DEPTH     (LDD)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_data_i       (ex_data_i),
    .ld_issue_valid_i(ld_issue_valid_i),
    .ld_issue_ready_o(ld_issue_ready_o),
    .ld_issue_rd_i   (ld_issue_rd_i),
    .ld_rsp_valid_i  (ld_rsp_valid_i),
    .ld_rsp_data_i   (ld_rsp_data_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rd_addr_i    (id_rd_addr_i),
    .hazard_o        (hazard_o),
    .rd_addr_o       (rd_addr_o),
    .rd_wr_data_o    (rd_wr_data_o),
    .rd_wr_en_o      (rd_wr_en_o),
    .ld_err_o        (ld_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ex_t;

  // Reference state: buffered EX results, pending load destinations, expected outputs
  ex_t           exq[$];
  logic [AW-1:0] ldq[$];
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hazard();
    logic h = 1'b0;
    foreach (ldq[i]) begin
      if (ldq[i] != '0 && (ldq[i] == id_rs1_addr_i || ldq[i] == id_rs2_addr_i ||
                           ldq[i] == id_rd_addr_i)) h = 1'b1;
    end
    foreach (exq[i]) begin
      if (exq[i].rd != '0 && (exq[i].rd == id_rs1_addr_i || exq[i].rd == id_rs2_addr_i)) h = 1'b1;
    end
    return h;
  endfunction

  task automatic idle_inputs();
    ex_valid_i       = 1'b0;
    ex_rd_addr_i     = '0;
    ex_data_i        = '0;
    ld_issue_valid_i = 1'b0;
    ld_issue_rd_i    = '0;
    ld_rsp_valid_i   = 1'b0;
    ld_rsp_data_i    = '0;
    id_rs1_addr_i    = '0;
    id_rs2_addr_i    = '0;
    id_rd_addr_i     = '0;
  endtask

  task automatic model_reset();
    exq.delete();
    ldq.delete();
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    logic          ld_rdy, ex_rdy, fire, pop_ld, wv;
    logic [AW-1:0] wrd;
    logic [DW-1:0] wd;
    ex_t           e;
    #2;
    ld_rdy = (ldq.size() < LDD);
    ex_rdy = (exq.size() < EXD);
    chk("ex_ready", 64'(ex_ready_o), 64'(ex_rdy));
    chk("ld_issue_ready", 64'(ld_issue_ready_o), 64'(ld_rdy));
    chk("hazard", 64'(hazard_o), 64'(m_hazard()));
    fire   = ex_valid_i && ex_rdy;
    pop_ld = ld_rsp_valid_i && (ldq.size() > 0);
    if (ld_rsp_valid_i && ldq.size() == 0) m_err = 1'b1;
    wv  = 1'b0;
    wrd = '0;
    wd  = '0;
    e.rd   = ex_rd_addr_i;
    e.data = ex_data_i;
    if (pop_ld) begin
      wv  = 1'b1;
      wrd = ldq.pop_front();
      wd  = ld_rsp_data_i;
      if (fire) exq.push_back(e);
    end else if (exq.size() > 0) begin
      ex_t h;
      h   = exq.pop_front();
      wv  = 1'b1;
      wrd = h.rd;
      wd  = h.data;
      if (fire) exq.push_back(e);
    end else if (fire) begin
      wv  = 1'b1;
      wrd = ex_rd_addr_i;
      wd  = ex_data_i;
    end
    if (ld_issue_valid_i && (ld_rdy || pop_ld)) ldq.push_back(ld_issue_rd_i);
    m_en = wv && (wrd != '0);
    if (wv) begin
      m_addr = wrd;
      m_data = wd;
    end
    @(posedge clk_i);
    #1;
    chk("wr_en", 64'(rd_wr_en_o), 64'(m_en));
    if (m_en) begin
      chk("wr_addr", 64'(rd_addr_o), 64'(m_addr));
      chk("wr_data", 64'(rd_wr_data_o), 64'(m_data));
    end
    chk("ld_err", 64'(ld_err_o), 64'(m_err));
  endtask

  task automatic probe_hz(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic [AW-1:0] rdd, input logic exp, input string tag);
    id_rs1_addr_i = r1;
    id_rs2_addr_i = r2;
    id_rd_addr_i  = rdd;
    #1;
    chk(tag, 64'(hazard_o), 64'(exp));
  endtask

  initial begin
    int ex_cnt;
    logic acc;

    // Power-on reset
    idle_inputs();
    model_reset();
    reset_i = 1'b1;
    #3;
    chk("rst_wr_en", 64'(rd_wr_en_o), 64'd0);
    chk("rst_addr", 64'(rd_addr_o), 64'd0);
    chk("rst_data", 64'(rd_wr_data_o), 64'd0);
    chk("rst_err", 64'(ld_err_o), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready_o), 64'd1);
    chk("rst_ld_ready", 64'(ld_issue_ready_o), 64'd1);
    chk("rst_hazard", 64'(hazard_o), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    step();

    // EX bypass: single-cycle pulse one cycle after acceptance
    ex_valid_i = 1'b1; ex_rd_addr_i = AW'(5); ex_data_i = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk("bypass_addr", 64'(rd_addr_o), 64'd5);
    chk("bypass_data", 64'(rd_wr_data_o), 64'hDEADBEEF);
    step();

    // Contention: load response beats a same-cycle EX result
    ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(7);
    step();
    idle_inputs();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h11;
    ex_valid_i = 1'b1; ex_rd_addr_i = AW'(3); ex_data_i = 32'h22;
    step();
    idle_inputs();
    chk("cont_ld_addr", 64'(rd_addr_o), 64'd7);
    chk("cont_ld_data", 64'(rd_wr_data_o), 64'h11);
    step();
    chk("cont_ex_addr", 64'(rd_addr_o), 64'd3);
    chk("cont_ex_data", 64'(rd_wr_data_o), 64'h22);

    // Backpressure: back-to-back responses while EX pushes every cycle
    for (int i = 0; i < 3; i++) begin
      ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(10 + i);
      step();
    end
    idle_inputs();
    ex_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      ld_rsp_valid_i = (c < 3);
      ld_rsp_data_i  = 32'h100 + 32'(c);
      ex_valid_i     = (ex_cnt < 5);
      ex_rd_addr_i   = AW'(13 + ex_cnt);
      ex_data_i      = 32'hA000 + 32'(ex_cnt);
      acc = ex_valid_i && (exq.size() < EXD);
      step();
      if (acc) ex_cnt++;
      if (c == 1) chk("bp_full", 64'(ex_ready_o), 64'd0);
    end
    idle_inputs();
    repeat (4) step();
    chk("bp_all_accepted", 64'(ex_cnt), 64'd5);

    // Hazard on a pending load to x9
    ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(9);
    step();
    idle_inputs();
    probe_hz(AW'(9), AW'(0), AW'(0), 1'b1, "hz_rs1");
    probe_hz(AW'(0), AW'(9), AW'(0), 1'b1, "hz_rs2");
    probe_hz(AW'(0), AW'(0), AW'(9), 1'b1, "hz_rd");
    probe_hz(AW'(0), AW'(0), AW'(0), 1'b0, "hz_x0");
    probe_hz(AW'(8), AW'(0), AW'(0), 1'b0, "hz_other");
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h99;
    step();
    ld_rsp_valid_i = 1'b0;
    chk("hz_x9_write", 64'(rd_addr_o), 64'd9);
    probe_hz(AW'(9), AW'(9), AW'(9), 1'b0, "hz_cleared");
    step();

    // x0 results are consumed silently, both bypassed and from the FIFO
    idle_inputs();
    ex_valid_i = 1'b1; ex_rd_addr_i = '0; ex_data_i = 32'h5555;
    step();
    idle_inputs();
    ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(6);
    step();
    idle_inputs();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h66;
    ex_valid_i = 1'b1; ex_rd_addr_i = '0; ex_data_i = 32'h7777;
    step();
    idle_inputs();
    step();
    chk("x0_no_write", 64'(rd_wr_en_o), 64'd0);
    step();

    // Pending table fills after LD_PEND_DEPTH issues
    for (int i = 0; i < LDD; i++) begin
      ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(16 + i);
      step();
    end
    idle_inputs();
    chk("ld_full", 64'(ld_issue_ready_o), 64'd0);
    step();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h1616;
    step();
    idle_inputs();
    chk("ld_not_full", 64'(ld_issue_ready_o), 64'd1);
    repeat (3) begin
      ld_rsp_valid_i = 1'b1; ld_rsp_data_i = $urandom;
      step();
    end
    idle_inputs();

    // Spurious response sets the sticky error
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'hBAD;
    step();
    idle_inputs();
    chk("err_set", 64'(ld_err_o), 64'd1);
    repeat (2) step();

    // Reset mid-stream with 2 EX entries and 3 pending loads
    for (int i = 0; i < LDD; i++) begin
      ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(20 + i);
      step();
    end
    idle_inputs();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h2020;
    ex_valid_i = 1'b1; ex_rd_addr_i = AW'(24); ex_data_i = 32'h2424;
    ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(25);
    step();
    idle_inputs();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h2121;
    ex_valid_i = 1'b1; ex_rd_addr_i = AW'(26); ex_data_i = 32'h2626;
    step();
    idle_inputs();
    chk("pre_rst_ex_cnt", 64'(exq.size()), 64'd2);
    id_rs1_addr_i = AW'(22);
    id_rs2_addr_i = AW'(24);
    reset_i = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_wr_en", 64'(rd_wr_en_o), 64'd0);
    chk("mid_rst_addr", 64'(rd_addr_o), 64'd0);
    chk("mid_rst_data", 64'(rd_wr_data_o), 64'd0);
    chk("mid_rst_err", 64'(ld_err_o), 64'd0);
    chk("mid_rst_ex_ready", 64'(ex_ready_o), 64'd1);
    chk("mid_rst_ld_ready", 64'(ld_issue_ready_o), 64'd1);
    chk("mid_rst_hazard", 64'(hazard_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    idle_inputs();
    repeat (3) step();

    // A response in the same cycle as the first issue is an error
    ld_issue_valid_i = 1'b1; ld_issue_rd_i = AW'(4);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h4444;
    step();
    idle_inputs();
    chk("same_cycle_err", 64'(ld_err_o), 64'd1);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h4545;
    step();
    idle_inputs();
    chk("late_rsp_addr", 64'(rd_addr_o), 64'd4);

    // Random legal traffic
    for (int c = 0; c < 400; c++) begin
      ex_valid_i       = 1'($urandom_range(0, 1));
      ex_rd_addr_i     = AW'($urandom_range(0, 7));
      ex_data_i        = $urandom;
      ld_issue_valid_i = ($urandom_range(0, 2) == 0);
      ld_issue_rd_i    = AW'($urandom_range(0, 7));
      ld_rsp_valid_i   = (ldq.size() > 0) && ($urandom_range(0, 2) == 0);
      ld_rsp_data_i    = $urandom;
      id_rs1_addr_i    = AW'($urandom_range(0, 7));
      id_rs2_addr_i    = AW'($urandom_range(0, 7));
      id_rd_addr_i     = AW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    repeat (LDD + EXD + 2) begin
      ld_rsp_valid_i = (ldq.size() > 0);
      ld_rsp_data_i  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
